// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA raster defaults, axis-length helper and tile codes shared with the drawer
package vga_pkg;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int DEF_CLK_DIV    = 2;
  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_SYNC_DELAY = 1;

  localparam int DEF_H_TOTAL = axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

  localparam int SCREEN_WIDTH  = DEF_H_VISIBLE;
  localparam int SCREEN_HEIGHT = DEF_V_VISIBLE;
  localparam int BLOCK_WIDTH   = 32;

  typedef enum logic [1:0] {
    BDR = 2'd0,
    SKY = 2'd1,
    BLK = 2'd2,
    GND = 2'd3
  } tile_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the generator to the pixel drawer
interface vga_timing_gen_if;
  logic        pix_tick;
  logic [31:0] col;
  logic [31:0] row;
  logic        active;
  logic        hsync_n;
  logic        vsync_n;
  logic        frame_start;
  logic        vblank_start;

  modport master (
    output pix_tick, col, row, active, hsync_n, vsync_n, frame_start, vblank_start
  );

  modport slave (
    input pix_tick, col, row, active, hsync_n, vsync_n, frame_start, vblank_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with registered sync and visible decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        wrap_in,
  output logic [31:0] count,
  output logic        sync_n,
  output logic        visible,
  output logic        wrap_out
);

  localparam int          TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [31:0] LAST       = 32'(TOTAL - 1);
  localparam logic [31:0] SYNC_FIRST = 32'(VISIBLE + FRONT);
  localparam logic [31:0] SYNC_LAST  = 32'(VISIBLE + FRONT + SYNC - 1);
  localparam logic [31:0] VIS_END    = 32'(VISIBLE);

  logic        step;
  logic [31:0] next_count;

  always_comb begin
    step       = en & wrap_in;
    next_count = (count == LAST) ? 32'd0 : count + 32'd1;
  end

  assign wrap_out = step && (count == LAST);

  // sync/visible are decoded from the value being loaded so they line up with count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= LAST;
      sync_n  <= 1'b1;
      visible <= 1'b0;
    end else if (step) begin
      count   <= next_count;
      sync_n  <= !((next_count >= SYNC_FIRST) && (next_count <= SYNC_LAST));
      visible <= (next_count < VIS_END);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 raster generator; VGA_SYNC_DELAY_EN adds pixel-tick sync/active delay
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter int SYNC_DELAY = DEF_SYNC_DELAY
) (
  input  logic             clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0]      VBLANK_ROW = 32'(V_VISIBLE - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick_c;
  logic             h_wrap;
  logic             v_wrap;
  logic             h_sync_n;
  logic             v_sync_n;
  logic             h_vis;
  logic             v_vis;
  logic [31:0]      col;
  logic [31:0]      row;

  assign tick_c = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Event strobes are taken from the advancing edge itself, so they last one clk for any divider
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga.pix_tick     <= 1'b0;
      vga.frame_start  <= 1'b0;
      vga.vblank_start <= 1'b0;
    end else begin
      vga.pix_tick     <= tick_c;
      vga.frame_start  <= v_wrap;
      vga.vblank_start <= h_wrap && (row == VBLANK_ROW);
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (tick_c),
    .wrap_in  (1'b1),
    .count    (col),
    .sync_n   (h_sync_n),
    .visible  (h_vis),
    .wrap_out (h_wrap)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (h_wrap),
    .wrap_in  (1'b1),
    .count    (row),
    .sync_n   (v_sync_n),
    .visible  (v_vis),
    .wrap_out (v_wrap)
  );

  assign vga.col = col;
  assign vga.row = row;

`ifdef VGA_SYNC_DELAY_EN
  logic [SYNC_DELAY-1:0] hs_sr;
  logic [SYNC_DELAY-1:0] vs_sr;
  logic [SYNC_DELAY-1:0] act_sr;

  // Stage 0 captures the undelayed flags as they stand before this pixel advance
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_sr  <= '1;
      vs_sr  <= '1;
      act_sr <= '0;
    end else if (tick_c) begin
      for (int i = SYNC_DELAY - 1; i > 0; i--) begin
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
        act_sr[i] <= act_sr[i-1];
      end
      hs_sr[0]  <= h_sync_n;
      vs_sr[0]  <= v_sync_n;
      act_sr[0] <= h_vis & v_vis;
    end
  end

  assign vga.hsync_n = hs_sr[SYNC_DELAY-1];
  assign vga.vsync_n = vs_sr[SYNC_DELAY-1];
  assign vga.active  = act_sr[SYNC_DELAY-1];
`else
  assign vga.hsync_n = h_sync_n;
  assign vga.vsync_n = v_sync_n;
  assign vga.active  = h_vis & v_vis;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized reset/run bench against a tick-count raster model
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int SH_V = 12, SH_F = 3, SH_S = 5, SH_B = 4;
  localparam int SV_V = 6,  SV_F = 2, SV_S = 3, SV_B = 4;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  typedef struct packed {
    logic        pix_tick;
    logic [31:0] col;
    logic [31:0] row;
    logic        active;
    logic        hsync_n;
    logic        vsync_n;
    logic        frame_start;
    logic        vblank_start;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   ecnt = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   c_hs_ticks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset_n) ecnt = 0;
    else ecnt = ecnt + 1;
  end

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen #(.CLK_DIV(2), .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
                   .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .SYNC_DELAY(1))
    dut_a (.clk(clk), .reset_n(reset_n), .vga(if_a));

  vga_timing_gen #(.CLK_DIV(1), .H_VISIBLE(SH_V), .H_FRONT(SH_F), .H_SYNC(SH_S), .H_BACK(SH_B),
                   .V_VISIBLE(SV_V), .V_FRONT(SV_F), .V_SYNC(SV_S), .V_BACK(SV_B), .SYNC_DELAY(1))
    dut_b (.clk(clk), .reset_n(reset_n), .vga(if_b));

  vga_timing_gen dut_c (.clk(clk), .reset_n(reset_n), .vga(if_c));

  // e = clk edges since reset release; position follows from the number of completed pixel ticks
  function automatic exp_t model(input int e, input int d,
                                 input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb,
                                 input int dly);
    exp_t x;
    int ht, vt, tot, n, p, q, c, r;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    tot = ht * vt;
    n = e / d;
    x.pix_tick     = (e > 0) && (e % d == 0);
    x.col          = 32'(ht - 1);
    x.row          = 32'(vt - 1);
    x.active       = 1'b0;
    x.hsync_n      = 1'b1;
    x.vsync_n      = 1'b1;
    x.frame_start  = 1'b0;
    x.vblank_start = 1'b0;
    if (n >= 1) begin
      p = (n - 1) % tot;
      x.col          = 32'(p % ht);
      x.row          = 32'(p / ht);
      x.frame_start  = x.pix_tick && (p == 0);
      x.vblank_start = x.pix_tick && (p == vv * ht);
    end
    if (n - dly >= 1) begin
      q = (n - dly - 1) % tot;
      c = q % ht;
      r = q / ht;
      x.active  = (c < hv) && (r < vv);
      x.hsync_n = !((c >= hv + hf) && (c < hv + hf + hs));
      x.vsync_n = !((r >= vv + vf) && (r < vv + vf + vs));
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, ecnt);
  endtask

  task automatic check_inst(input string p, input exp_t x, input logic pt,
                            input logic [31:0] c, input logic [31:0] r, input logic ac,
                            input logic hs, input logic vs, input logic fs, input logic vb);
    check({p, "_pix_tick"},     32'(pt), 32'(x.pix_tick));
    check({p, "_col"},          c,       x.col);
    check({p, "_row"},          r,       x.row);
    check({p, "_active"},       32'(ac), 32'(x.active));
    check({p, "_hsync_n"},      32'(hs), 32'(x.hsync_n));
    check({p, "_vsync_n"},      32'(vs), 32'(x.vsync_n));
    check({p, "_frame_start"},  32'(fs), 32'(x.frame_start));
    check({p, "_vblank_start"}, 32'(vb), 32'(x.vblank_start));
  endtask

  task automatic check_all(input int e);
    check_inst("a", model(e, 2, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, DLY),
               if_a.pix_tick, if_a.col, if_a.row, if_a.active, if_a.hsync_n, if_a.vsync_n,
               if_a.frame_start, if_a.vblank_start);
    check_inst("b", model(e, 1, SH_V, SH_F, SH_S, SH_B, SV_V, SV_F, SV_S, SV_B, DLY),
               if_b.pix_tick, if_b.col, if_b.row, if_b.active, if_b.hsync_n, if_b.vsync_n,
               if_b.frame_start, if_b.vblank_start);
    check_inst("c", model(e, 2, SCREEN_WIDTH, 16, 96, 48, SCREEN_HEIGHT, 10, 2, 33, DLY),
               if_c.pix_tick, if_c.col, if_c.row, if_c.active, if_c.hsync_n, if_c.vsync_n,
               if_c.frame_start, if_c.vblank_start);
  endtask

  initial begin
    int run;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all(0);

    for (int iter = 0; iter < 6; iter++) begin
      @(posedge clk);
      #2 reset_n = 1'b1;
      run = (iter == 0) ? 3400 : int'($urandom_range(150, 1500));
      for (int k = 0; k < run; k++) begin
        @(negedge clk);
        check_all(ecnt);
        if (iter == 0 && if_c.pix_tick && !if_c.hsync_n && if_c.row == 32'd0) c_hs_ticks++;
      end
      if (iter == 0) check("c_line0_hsync_ticks", 32'(c_hs_ticks), 32'd96);

      // reset lands between clock edges and must take effect without one
      @(posedge clk);
      #($urandom_range(1, 3)) reset_n = 1'b0;
      #1 check_all(0);
      repeat ($urandom_range(1, 4)) begin
        @(negedge clk);
        check_all(0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
